cpa_modq_pipe: RTL

//   Carry-propagate + modular-correction stage fed directly by the sel_nq carry-save compressor.
//   - Adds the column-aligned sum/carry vectors (s, c) into one binary value r = (s + c) mod 2^W.
//   - Folds r into [0,Q) with one conditional subtract of Q.
//   - Two-stage valid/ready pipeline. A sideband tag travels with each datum.

---
 rtl/cpa_modq_pipe.sv | 122 ++++++++++++
 1 files changed

// File: rtl/cpa_modq_pipe.sv
// cpa_modq_pipe: carry-propagate add of a carry-save pair followed by one
// conditional subtract of Q. Two-stage valid/ready pipeline with a sideband tag.
// Optional feature macro: CPA_MODQ_RANGE_CHK_EN enables the sticky range_err flag
// (raised when the stage-A sum is >= 2Q and so cannot be fully reduced).
module cpa_modq_pipe #(
    parameter int unsigned W     = 15,
    parameter int unsigned Q     = 3329,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     s,
    input  logic [W-1:0]     c,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     r_out,
    output logic [TAG_W-1:0] out_tag,
    output logic             range_err,
    input  logic             err_clr
);

    localparam logic [W-1:0] QW = W'(Q);

    logic             va_q;
    logic [W-1:0]     suma_q;
    logic [TAG_W-1:0] taga_q;
    logic             vb_q;
    logic [W-1:0]     r_q;
    logic [TAG_W-1:0] tagb_q;

    logic             ready_b;
    logic             load_a;
    logic             load_b;
    logic [W-1:0]     sum_in;
    logic [W-1:0]     red;

    // Ready chain, sum of the carry-save pair and the single-step reduction
    always_comb begin
        ready_b  = !vb_q || out_ready;
        in_ready = !va_q || ready_b;
        load_a   = in_valid && in_ready;
        load_b   = va_q && ready_b;
        // carry out of bit W-1 is dropped by the W-bit result
        sum_in   = s + c;
        red      = (suma_q >= QW) ? (suma_q - QW) : suma_q;
    end

    // Stage A: capture the binary sum and tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            va_q   <= 1'b0;
            suma_q <= '0;
            taga_q <= '0;
        end else begin
            if (load_a) begin
                suma_q <= sum_in;
                taga_q <= in_tag;
            end
            if (load_a) begin
                va_q <= 1'b1;
            end else if (load_b) begin
                va_q <= 1'b0;
            end
        end
    end

    // Stage B: capture the reduced result; r_out holds its value while empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vb_q   <= 1'b0;
            r_q    <= '0;
            tagb_q <= '0;
        end else begin
            if (load_b) begin
                r_q    <= red;
                tagb_q <= taga_q;
            end
            if (load_b) begin
                vb_q <= 1'b1;
            end else if (out_ready) begin
                vb_q <= 1'b0;
            end
        end
    end

    assign out_valid = vb_q;
    assign r_out     = r_q;
    assign out_tag   = tagb_q;

`ifdef CPA_MODQ_RANGE_CHK_EN
    localparam logic [W-1:0] Q2W = W'(2 * Q);

    logic range_err_q;
    logic ge_a;

    // Sum too large for one subtract to bring it into [0,Q)
    always_comb begin
        ge_a = (suma_q >= Q2W);
    end

    // Sticky error flag; a new error in the clear cycle takes priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            range_err_q <= 1'b0;
        end else if (load_b && ge_a) begin
            range_err_q <= 1'b1;
        end else if (err_clr) begin
            range_err_q <= 1'b0;
        end
    end

    assign range_err = range_err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign range_err      = 1'b0;
`endif

endmodule
